// File: rtl/generic_fifo_reader.sv
// Read-side drain engine for generic_fifo: pops words, absorbs the 1-cycle read latency
// in a 2-entry skid buffer and presents them as a registered valid/ready stream.
module generic_fifo_reader #(
    parameter int unsigned GENERIC_FIFO_DATA_WIDTH = 4,
    parameter int unsigned COUNT_WIDTH             = 16
) (
    input  logic                               clk,
    input  logic                               reset_poweron,
    input  logic                               clear,
    output logic                               fifo_read,
    input  logic [GENERIC_FIFO_DATA_WIDTH-1:0] fifo_read_data,
    input  logic                               fifo_empty,
    output logic                               out_valid,
    output logic [GENERIC_FIFO_DATA_WIDTH-1:0] out_data,
    input  logic                               out_ready,
    output logic                               inflight,
    output logic [COUNT_WIDTH-1:0]             delivered_count
);

    localparam int unsigned DW = GENERIC_FIFO_DATA_WIDTH;

    logic [1:0]    occ;
    logic [1:0]    occ_n;
    logic [DW-1:0] tail;
    logic [DW-1:0] tail_n;
    logic [DW-1:0] head_n;
    logic          pop;
    logic          capture;
    logic [2:0]    pending;

    assign pop     = out_valid & out_ready;
    assign capture = inflight;

    // Words already owned (skid + in flight) after this cycle's pop must stay below 2,
    // so every returning word is guaranteed a free slot.
    assign pending   = 3'(occ) + 3'(inflight);
    assign fifo_read = ~fifo_empty & ~reset_poweron & ~clear
                     & (pending < (3'd2 + 3'(pop)));

    // Skid next state: head is the presented word, tail the one behind it.
    always_comb begin
        occ_n  = occ;
        head_n = out_data;
        tail_n = tail;
        case (occ)
            2'd0: begin
                if (capture) begin
                    head_n = fifo_read_data;
                    occ_n  = 2'd1;
                end
            end
            2'd1: begin
                if (capture && pop) begin
                    head_n = fifo_read_data;
                end else if (capture) begin
                    tail_n = fifo_read_data;
                    occ_n  = 2'd2;
                end else if (pop) begin
                    occ_n  = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_n = tail;
                    if (capture) begin
                        tail_n = fifo_read_data;
                    end else begin
                        occ_n  = 2'd1;
                    end
                end
            end
            default: begin
                occ_n = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            occ             <= 2'd0;
            out_valid       <= 1'b0;
            out_data        <= '0;
            tail            <= '0;
            inflight        <= 1'b0;
            delivered_count <= '0;
        end else begin
            if (pop) begin
                delivered_count <= delivered_count + COUNT_WIDTH'(1);
            end
            // clear discards the skid and any word returning at this edge
            if (clear) begin
                occ       <= 2'd0;
                out_valid <= 1'b0;
                out_data  <= '0;
                tail      <= '0;
                inflight  <= 1'b0;
            end else begin
                occ       <= occ_n;
                out_valid <= (occ_n != 2'd0);
                out_data  <= head_n;
                tail      <= tail_n;
                inflight  <= fifo_read;
            end
        end
    end

    skid_overflow: assert property (@(posedge clk) disable iff (reset_poweron || clear)
                                    !(capture && !pop && occ == 2'd2));

endmodule

// File: tb/tb_generic_fifo_reader.sv
// Bench for generic_fifo_reader: queue-based FIFO model in front, in-order scoreboard behind.
module tb_generic_fifo_reader;

    localparam int unsigned DW  = 4;
    localparam int unsigned CW  = 16;
    localparam int unsigned CW4 = 4;

    logic          clk = 1'b0;
    logic          reset_poweron = 1'b1;
    logic          clear = 1'b0;
    logic          out_ready = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_read_data = '0;

    logic          fifo_read, fifo_read4;
    logic          out_valid, out_valid4;
    logic [DW-1:0] out_data, out_data4;
    logic          inflight, inflight4;
    logic [CW-1:0] delivered_count;
    logic [CW4-1:0] delivered_count4;

    int errors = 0;
    int checks = 0;
    int model_count = 0;
    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    generic_fifo_reader #(.GENERIC_FIFO_DATA_WIDTH(DW), .COUNT_WIDTH(CW)) u_dut (
        .clk(clk), .reset_poweron(reset_poweron), .clear(clear),
        .fifo_read(fifo_read), .fifo_read_data(fifo_read_data), .fifo_empty(fifo_empty),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .inflight(inflight), .delivered_count(delivered_count)
    );

    generic_fifo_reader #(.GENERIC_FIFO_DATA_WIDTH(DW), .COUNT_WIDTH(CW4)) u_dut4 (
        .clk(clk), .reset_poweron(reset_poweron), .clear(clear),
        .fifo_read(fifo_read4), .fifo_read_data(fifo_read_data), .fifo_empty(fifo_empty),
        .out_valid(out_valid4), .out_data(out_data4), .out_ready(out_ready),
        .inflight(inflight4), .delivered_count(delivered_count4)
    );

    // FIFO model: read data valid the cycle after fifo_read, empty lags a write by one cycle
    always @(posedge clk) begin
        if (clear) begin
            fq.delete();
            fifo_empty <= 1'b1;
        end else begin
            if (fifo_read && fq.size() > 0) fifo_read_data <= fq.pop_front();
            if (wr_en) fq.push_back(wr_data);
            fifo_empty <= (fq.size() == 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_write(input logic en, input logic [DW-1:0] d);
        wr_en   = en;
        wr_data = d;
        if (en) exp_q.push_back(d);
    endtask

    task automatic test_reset();
        reset_poweron = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            drive_write(k < 2, DW'(k + 5));
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || out_data !== '0 || inflight !== 1'b0 || delivered_count !== '0) begin
                errors++;
                $display("FAIL reset_outputs: valid=%b data=%h inflight=%b count=%h, required 0/0/0/0",
                         out_valid, out_data, inflight, delivered_count);
            end
            if (k >= 2) begin
                checks++;
                if (fifo_read !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_gates_read: fifo_read=%b with empty=%b, required 0", fifo_read, fifo_empty);
                end
            end
        end
        tick();
        drive_write(1'b0, '0);
        reset_poweron = 1'b0;
        clear = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (fifo_read !== 1'b0) begin
            errors++;
            $display("FAIL clear_gates_read: fifo_read=%b with empty=%b, required 0", fifo_read, fifo_empty);
        end
        tick();
        clear = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || inflight !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: valid=%b inflight=%b, required 0/0", out_valid, inflight);
        end
        model_count = 0;
    endtask

    task automatic test_basic();
        int pops = 0;
        logic [DW-1:0] w;
        logic exp_rd, exp_v;
        for (int k = 0; k < 12; k++) begin
            tick();
            drive_write(k < 3, DW'(k + 1));
            out_ready = 1'b1;
            @(negedge clk);
            exp_rd = (k >= 1 && k <= 3);
            exp_v  = (k >= 3 && k <= 5);
            checks++;
            if (fifo_read !== exp_rd) begin
                errors++;
                $display("FAIL basic_read_k%0d: fifo_read=%b, required %b", k, fifo_read, exp_rd);
            end
            checks++;
            if (out_valid !== exp_v) begin
                errors++;
                $display("FAIL basic_valid_k%0d: out_valid=%b, required %b", k, out_valid, exp_v);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL basic_order: unexpected word %h, required none", out_data);
                end else begin
                    w = exp_q.pop_front();
                    if (out_data !== w) begin
                        errors++;
                        $display("FAIL basic_order: out_data=%h, required %h", out_data, w);
                    end
                end
                pops++;
                model_count++;
            end
        end
        checks++;
        if (pops != 3 || delivered_count !== 16'd3) begin
            errors++;
            $display("FAIL basic_count: pops=%0d count=%0d, required 3/3", pops, delivered_count);
        end
    endtask

    task automatic test_backpressure();
        int rd_pulses = 0;
        int pops = 0;
        int first_k = -1;
        int last_k = -1;
        logic [DW-1:0] w;
        out_ready = 1'b0;
        for (int k = 0; k < 14; k++) begin
            tick();
            drive_write(k < 8, DW'(k + 1));
            @(negedge clk);
            if (fifo_read) rd_pulses++;
        end
        checks++;
        if (rd_pulses != 2 || fq.size() != 6) begin
            errors++;
            $display("FAIL bp_prefetch: reads=%0d depth=%0d, required 2/6", rd_pulses, fq.size());
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'h1 || inflight !== 1'b0) begin
            errors++;
            $display("FAIL bp_head: valid=%b data=%h inflight=%b, required 1/1/0", out_valid, out_data, inflight);
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            drive_write(1'b0, '0);
            out_ready = 1'b1;
            @(negedge clk);
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_order: unexpected word %h, required none", out_data);
                end else begin
                    w = exp_q.pop_front();
                    if (out_data !== w) begin
                        errors++;
                        $display("FAIL bp_order: out_data=%h, required %h", out_data, w);
                    end
                end
                if (first_k < 0) first_k = k;
                last_k = k;
                pops++;
                model_count++;
            end
        end
        checks++;
        if (pops != 8 || (last_k - first_k) != 7) begin
            errors++;
            $display("FAIL bp_stream: pops=%0d span=%0d, required 8/7", pops, last_k - first_k);
        end
        checks++;
        if (delivered_count !== CW'(model_count)) begin
            errors++;
            $display("FAIL bp_count: count=%0d, required %0d", delivered_count, model_count);
        end
    endtask

    task automatic test_toggle();
        int pops = 0;
        logic hold = 1'b0;
        logic [DW-1:0] held = '0;
        logic [DW-1:0] w;
        for (int k = 0; k < 40 && !(k >= 6 && pops == 6); k++) begin
            tick();
            drive_write(k < 6, DW'(4'hA + k));
            out_ready = (k % 2 == 0);
            @(negedge clk);
            if (hold) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    errors++;
                    $display("FAIL toggle_stable: valid=%b data=%h, required 1/%h", out_valid, out_data, held);
                end
            end
            hold = out_valid && !out_ready;
            held = out_data;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL toggle_order: unexpected word %h, required none", out_data);
                end else begin
                    w = exp_q.pop_front();
                    if (out_data !== w) begin
                        errors++;
                        $display("FAIL toggle_order: out_data=%h, required %h", out_data, w);
                    end
                end
                pops++;
                model_count++;
            end
        end
        checks++;
        if (pops != 6 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL toggle_total: pops=%0d left=%0d, required 6/0", pops, exp_q.size());
        end
    endtask

    task automatic test_clear();
        int pops = 0;
        logic [DW-1:0] w;
        for (int k = 0; k < 7; k++) begin
            tick();
            if (k == 6) begin
                checks++;
                if (out_valid !== 1'b1 || inflight !== 1'b1) begin
                    errors++;
                    $display("FAIL clear_setup: valid=%b inflight=%b, required 1/1", out_valid, inflight);
                end
            end
            drive_write(k < 6, DW'(k + 1));
            out_ready = (k < 6);
            clear = (k == 6);
            if (clear) exp_q.delete();
            @(negedge clk);
            if (k == 6) begin
                checks++;
                if (fifo_read !== 1'b0) begin
                    errors++;
                    $display("FAIL clear_read: fifo_read=%b, required 0", fifo_read);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL clear_pre_order: unexpected word %h, required none", out_data);
                end else begin
                    w = exp_q.pop_front();
                    if (out_data !== w) begin
                        errors++;
                        $display("FAIL clear_pre_order: out_data=%h, required %h", out_data, w);
                    end
                end
                model_count++;
            end
        end
        tick();
        clear = 1'b0;
        drive_write(1'b0, '0);
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || inflight !== 1'b0 || delivered_count !== CW'(model_count)) begin
            errors++;
            $display("FAIL clear_flush: valid=%b inflight=%b count=%0d, required 0/0/%0d",
                     out_valid, inflight, delivered_count, model_count);
        end
        tick();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || fifo_read !== 1'b0) begin
            errors++;
            $display("FAIL clear_discard: valid=%b fifo_read=%b, required 0/0", out_valid, fifo_read);
        end
        for (int k = 0; k < 15; k++) begin
            tick();
            drive_write(k < 2, DW'(7 + k));
            @(negedge clk);
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL clear_post_order: unexpected word %h, required none", out_data);
                end else begin
                    w = exp_q.pop_front();
                    if (out_data !== w) begin
                        errors++;
                        $display("FAIL clear_post_order: out_data=%h, required %h", out_data, w);
                    end
                end
                pops++;
                model_count++;
            end
        end
        checks++;
        if (pops != 2) begin
            errors++;
            $display("FAIL clear_post_total: pops=%0d, required 2", pops);
        end
    endtask

    task automatic test_idle();
        reset_poweron = 1'b1;
        tick();
        tick();
        reset_poweron = 1'b0;
        model_count = 0;
        @(negedge clk);
        checks++;
        if (delivered_count !== '0 || delivered_count4 !== '0) begin
            errors++;
            $display("FAIL idle_reset_count: count=%0d count4=%0d, required 0/0", delivered_count, delivered_count4);
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            out_ready = (k % 2 == 1);
            @(negedge clk);
            checks++;
            if (fifo_read !== 1'b0 || out_valid !== 1'b0 || delivered_count !== '0) begin
                errors++;
                $display("FAIL idle_k%0d: fifo_read=%b valid=%b count=%0d, required 0/0/0",
                         k, fifo_read, out_valid, delivered_count);
            end
        end
    endtask

    task automatic test_wrap();
        int pops = 0;
        logic prev_rd = 1'b0;
        logic [DW-1:0] w;
        for (int k = 0; k < 40 && pops < 17; k++) begin
            tick();
            drive_write(k < 17, DW'($urandom));
            out_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (delivered_count4 !== CW4'(model_count) || delivered_count !== CW'(model_count)) begin
                errors++;
                $display("FAIL wrap_count_k%0d: count4=%h count=%h, required %h/%h", k,
                         delivered_count4, delivered_count, CW4'(model_count), CW'(model_count));
            end
            checks++;
            if (inflight4 !== prev_rd) begin
                errors++;
                $display("FAIL wrap_inflight_k%0d: inflight=%b, required %b", k, inflight4, prev_rd);
            end
            prev_rd = fifo_read4;
            if (out_valid4 && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wrap_order: unexpected word %h, required none", out_data4);
                end else begin
                    w = exp_q.pop_front();
                    if (out_data4 !== w) begin
                        errors++;
                        $display("FAIL wrap_order: out_data=%h, required %h", out_data4, w);
                    end
                end
                pops++;
                model_count++;
            end
        end
        tick();
        @(negedge clk);
        checks++;
        if (pops != 17 || delivered_count4 !== 4'h1 || delivered_count !== 16'd17) begin
            errors++;
            $display("FAIL wrap_final: pops=%0d count4=%h count=%0d, required 17/1/17",
                     pops, delivered_count4, delivered_count);
        end
    endtask

    task automatic test_random();
        logic prev_rd = 1'b0;
        logic hold = 1'b0;
        logic [DW-1:0] held = '0;
        logic [DW-1:0] w;
        int k = 0;
        while (k < 800 && (k < 600 || exp_q.size() != 0 || out_valid)) begin
            tick();
            if (k < 300) begin
                drive_write(($urandom % 4) != 0, DW'($urandom));
                out_ready = (($urandom % 4) == 0);
            end else if (k < 600) begin
                drive_write(($urandom % 4) == 0, DW'($urandom));
                out_ready = (($urandom % 4) != 0);
            end else begin
                drive_write(1'b0, '0);
                out_ready = 1'b1;
            end
            @(negedge clk);
            checks++;
            if (delivered_count !== CW'(model_count) || inflight !== prev_rd) begin
                errors++;
                $display("FAIL rand_state_k%0d: count=%0d inflight=%b, required %0d/%b",
                         k, delivered_count, inflight, model_count, prev_rd);
            end
            prev_rd = fifo_read;
            if (hold) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    errors++;
                    $display("FAIL rand_stable_k%0d: valid=%b data=%h, required 1/%h", k, out_valid, out_data, held);
                end
            end
            hold = out_valid && !out_ready;
            held = out_data;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_order: unexpected word %h, required none", out_data);
                end else begin
                    w = exp_q.pop_front();
                    if (out_data !== w) begin
                        errors++;
                        $display("FAIL rand_order_k%0d: out_data=%h, required %h", k, out_data, w);
                    end
                end
                model_count++;
            end
            k++;
        end
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_drain: left=%0d valid=%b, required 0/0", exp_q.size(), out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_toggle();
        test_clear();
        test_idle();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
